// File: rtl/multicycle_ctrl_if.sv
// Instruction handshake, ALU/memory status and datapath control bundle for multicycle_ctrl.
// The slave side is the controller; the master side is fetch plus the datapath.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        alu_negative;
  logic        alu_zero;
  logic        alu_overflow;
  logic        alu_carry;
  logic        mem_done;
  logic        Reg2Loc;
  logic        ALUSrc;
  logic        IorR;
  logic        MemRead;
  logic        MemWrite;
  logic        MemToReg;
  logic        RegWrite;
  logic        Move;
  logic        ZorK;
  logic        Bor8;
  logic [2:0]  ALUOp;
  logic [3:0]  xfer;
  logic [3:0]  flags;
  logic        pc_update;
  logic        br_taken;
  logic        illegal;
  logic        mem_err;

  modport master (
    output instr, instr_valid, alu_negative, alu_zero, alu_overflow, alu_carry, mem_done,
    input  instr_ready, Reg2Loc, ALUSrc, IorR, MemRead, MemWrite, MemToReg, RegWrite,
           Move, ZorK, Bor8, ALUOp, xfer, flags, pc_update, br_taken, illegal, mem_err
  );

  modport slave (
    input  instr, instr_valid, alu_negative, alu_zero, alu_overflow, alu_carry, mem_done,
    output instr_ready, Reg2Loc, ALUSrc, IorR, MemRead, MemWrite, MemToReg, RegWrite,
           Move, ZorK, Bor8, ALUOp, xfer, flags, pc_update, br_taken, illegal, mem_err
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 control sequencer: IDLE -> DEC -> EX -> (MEM) -> (WB), driving all
// datapath controls, holding the NZVC flags and reporting retirement/branch decisions.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  multicycle_ctrl_if.slave bus
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_DEC, S_EX, S_MEM, S_WB} state_e;

  typedef enum logic [3:0] {
    OP_ILL, OP_ADDI, OP_ADDS, OP_SUBS, OP_LDUR, OP_STUR, OP_LDURB, OP_STURB,
    OP_MOVZ, OP_MOVK, OP_B, OP_CBZ, OP_BLT
  } op_e;

  typedef struct packed {
    logic       reg2loc;
    logic       alu_src;
    logic       ior_r;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       move;
    logic       zork;
    logic       bor8;
    logic [2:0] alu_op;
    logic [3:0] xfer;
    logic       pc_update;
    logic       br_taken;
    logic       illegal;
    logic       mem_err;
    logic       instr_ready;
  } ctl_t;

  state_e        state_q, state_d;
  logic [31:0]   ir_q, ir_d;
  logic [3:0]    flags_q, flags_d;
  logic [CW-1:0] cnt_q, cnt_d;
  op_e           op;
  ctl_t          ctl;
  logic          is_load;
  logic          unused_ir;

  always_comb begin
    op = OP_ILL;
    if      (ir_q[31:22] == 10'b1001000100)  op = OP_ADDI;
    else if (ir_q[31:21] == 11'b10101011000) op = OP_ADDS;
    else if (ir_q[31:21] == 11'b11101011000) op = OP_SUBS;
    else if (ir_q[31:21] == 11'b11111000010) op = OP_LDUR;
    else if (ir_q[31:21] == 11'b11111000000) op = OP_STUR;
    else if (ir_q[31:21] == 11'b00111000010) op = OP_LDURB;
    else if (ir_q[31:21] == 11'b00111000000) op = OP_STURB;
    else if (ir_q[31:23] == 9'b110100101)    op = OP_MOVZ;
    else if (ir_q[31:23] == 9'b111100101)    op = OP_MOVK;
    else if (ir_q[31:26] == 6'b000101)       op = OP_B;
    else if (ir_q[31:24] == 8'b10110100)     op = OP_CBZ;
    else if (ir_q[31:24] == 8'b01010100 && ir_q[3:0] == 4'b1011) op = OP_BLT;
  end

  assign is_load   = (op == OP_LDUR) || (op == OP_LDURB);
  assign unused_ir = ^ir_q[20:4];

  // ALU/address controls set up in EX and held through MEM and WB.
  function automatic ctl_t ex_ctl(op_e o);
    ctl_t c = '0;
    case (o)
      OP_ADDI: begin c.alu_src = 1'b1; c.alu_op = 3'b010; end
      OP_ADDS: begin c.reg2loc = 1'b1; c.alu_op = 3'b010; end
      OP_SUBS: begin c.reg2loc = 1'b1; c.alu_op = 3'b011; end
      OP_LDUR, OP_LDURB, OP_STUR, OP_STURB: begin
        c.alu_src = 1'b1;
        c.ior_r   = 1'b1;
        c.alu_op  = 3'b010;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctl_t mem_ctl(op_e o);
    ctl_t c = '0;
    c.mem_read  = (o == OP_LDUR) || (o == OP_LDURB);
    c.mem_write = (o == OP_STUR) || (o == OP_STURB);
    c.bor8      = (o == OP_LDURB) || (o == OP_STURB);
    if (c.mem_read || c.mem_write) c.xfer = c.bor8 ? 4'b0001 : 4'b1000;
    return c;
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d         = state_q;
    ir_d            = ir_q;
    flags_d         = flags_q;
    cnt_d           = '0;
    ctl             = '0;
    ctl.instr_ready = (state_q == S_IDLE);
    // A reset cycle drives no controls, pulses or writes, whatever the state.
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (bus.instr_valid) begin
            ir_d    = bus.instr;
            state_d = S_DEC;
          end
        end
        S_DEC: begin
          if (op == OP_ILL) begin
            ctl.illegal = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_EX;
          end
        end
        S_EX: begin
          ctl     = ex_ctl(op);
          state_d = S_WB;
          case (op)
            OP_ADDS, OP_SUBS:
              flags_d = {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry};
            OP_LDUR, OP_LDURB, OP_STUR, OP_STURB: state_d = S_MEM;
            OP_B:   begin ctl.pc_update = 1'b1; ctl.br_taken = 1'b1;                   state_d = S_IDLE; end
            OP_CBZ: begin ctl.pc_update = 1'b1; ctl.br_taken = bus.alu_zero;            state_d = S_IDLE; end
            OP_BLT: begin ctl.pc_update = 1'b1; ctl.br_taken = flags_q[3] ^ flags_q[1]; state_d = S_IDLE; end
            default: ;
          endcase
        end
        S_MEM: begin
          ctl   = ex_ctl(op) | mem_ctl(op);
          cnt_d = cnt_q + CW'(1);
          if (bus.mem_done) begin
            if (is_load) begin
              state_d = S_WB;
            end else begin
              ctl.pc_update = 1'b1;
              state_d       = S_IDLE;
            end
          end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
            ctl.mem_err = 1'b1;
            state_d     = S_IDLE;
          end
        end
        S_WB: begin
          ctl            = ex_ctl(op);
          if (is_load) ctl = ex_ctl(op) | mem_ctl(op);
          ctl.mem_to_reg = is_load;
          ctl.move       = (op == OP_MOVZ) || (op == OP_MOVK);
          ctl.zork       = (op == OP_MOVK);
          ctl.reg_write  = 1'b1;
          ctl.pc_update  = 1'b1;
          state_d        = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.instr_ready = ctl.instr_ready;
  assign bus.Reg2Loc     = ctl.reg2loc;
  assign bus.ALUSrc      = ctl.alu_src;
  assign bus.IorR        = ctl.ior_r;
  assign bus.MemRead     = ctl.mem_read;
  assign bus.MemWrite    = ctl.mem_write;
  assign bus.MemToReg    = ctl.mem_to_reg;
  assign bus.RegWrite    = ctl.reg_write;
  assign bus.Move        = ctl.move;
  assign bus.ZorK        = ctl.zork;
  assign bus.Bor8        = ctl.bor8;
  assign bus.ALUOp       = ctl.alu_op;
  assign bus.xfer        = ctl.xfer;
  assign bus.flags       = flags_q;
  assign bus.pc_update   = ctl.pc_update;
  assign bus.br_taken    = ctl.br_taken;
  assign bus.illegal     = ctl.illegal;
  assign bus.mem_err     = ctl.mem_err;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random instructions compared against a
// per-instruction model built from latencies, flag rules and expected control settings.
module tb_multicycle_ctrl;

  localparam int MEM_TIMEOUT = 16;

  typedef enum int {
    T_ADDI, T_ADDS, T_SUBS, T_LDUR, T_STUR, T_LDURB, T_STURB,
    T_MOVZ, T_MOVK, T_B, T_CBZ, T_BLT, T_ILL
  } op_t;

  logic       clk = 1'b0;
  logic       reset;
  int         checks = 0;
  int         errors = 0;
  int         run_no = 0;
  logic [3:0] model_flags;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] ctl_vec();
    return {bus.Reg2Loc, bus.ALUSrc, bus.IorR, bus.MemRead, bus.MemWrite, bus.MemToReg,
            bus.RegWrite, bus.Move, bus.ZorK, bus.Bor8, bus.ALUOp, bus.xfer,
            bus.pc_update, bus.br_taken, bus.illegal, bus.mem_err};
  endfunction

  function automatic logic [31:0] make_ins(op_t op);
    case (op)
      T_ADDI:  return {10'b1001000100, 22'($urandom)};
      T_ADDS:  return {11'b10101011000, 21'($urandom)};
      T_SUBS:  return {11'b11101011000, 21'($urandom)};
      T_LDUR:  return {11'b11111000010, 21'($urandom)};
      T_STUR:  return {11'b11111000000, 21'($urandom)};
      T_LDURB: return {11'b00111000010, 21'($urandom)};
      T_STURB: return {11'b00111000000, 21'($urandom)};
      T_MOVZ:  return {9'b110100101, 23'($urandom)};
      T_MOVK:  return {9'b111100101, 23'($urandom)};
      T_B:     return {6'b000101, 26'($urandom)};
      T_CBZ:   return {8'b10110100, 24'($urandom)};
      T_BLT:   return {8'b01010100, 19'($urandom), 1'b0, 4'b1011};
      default: return {11'h7FF, 21'($urandom)};
    endcase
  endfunction

  // {Reg2Loc, ALUSrc, IorR, ALUOp} expected during EX.
  function automatic logic [5:0] exp_ex(op_t op);
    case (op)
      T_ADDI:                          return 6'b0_1_0_010;
      T_ADDS:                          return 6'b1_0_0_010;
      T_SUBS:                          return 6'b1_0_0_011;
      T_LDUR, T_STUR, T_LDURB, T_STURB: return 6'b0_1_1_010;
      default:                         return 6'b0;
    endcase
  endfunction

  // {MemToReg, Move, ZorK, ALUOp, RegWrite} expected in the write-back cycle.
  function automatic logic [6:0] exp_wb(op_t op);
    case (op)
      T_ADDI, T_ADDS:  return 7'b0_0_0_010_1;
      T_SUBS:          return 7'b0_0_0_011_1;
      T_LDUR, T_LDURB: return 7'b1_0_0_010_1;
      T_MOVZ:          return 7'b0_1_0_000_1;
      T_MOVK:          return 7'b0_1_1_000_1;
      default:         return 7'b0;
    endcase
  endfunction

  // Issue one instruction; k = cycles from MEM entry to mem_done (>= MEM_TIMEOUT means never),
  // rst_cyc > 0 asserts reset in that cycle after acceptance.
  task automatic run(input op_t op, input logic [31:0] ins, input logic [3:0] ex_nzvc,
                     input int k, input int rst_cyc);
    bit         is_ld, is_st, is_mem, is_ill, is_alu, byte_op, tmo, exp_pc, exp_rw, exp_br;
    int         last, mem_last, exp_mw;
    logic [3:0] exp_flags;
    int         pc_cnt = 0, pc_cyc = -1, rw_cnt = 0, mw_cnt = 0, mr_cnt = 0;
    int         il_cnt = 0, me_cnt = 0, busy_ready = 0;
    logic       br_seen = 1'b0, ready_after = 1'b0;
    logic [5:0] ex_snap = '0;
    logic [6:0] mem_snap = '0, wb_snap = '0;
    logic [20:0] idle_ctl = '0;
    logic [3:0] flags_after = '0;
    string      pfx;

    run_no++;
    pfx     = $sformatf("%s#%0d_", op.name(), run_no);
    is_ld   = (op == T_LDUR) || (op == T_LDURB);
    is_st   = (op == T_STUR) || (op == T_STURB);
    is_mem  = is_ld || is_st;
    byte_op = (op == T_LDURB) || (op == T_STURB);
    is_ill  = (op == T_ILL);
    is_alu  = (op == T_ADDI) || (op == T_ADDS) || (op == T_SUBS) || (op == T_MOVZ) || (op == T_MOVK);
    tmo     = is_mem && (k > MEM_TIMEOUT - 1);

    if (is_ill)      last = 1;
    else if (is_alu) last = 3;
    else if (is_mem) last = tmo ? 3 + MEM_TIMEOUT - 1 : (is_ld ? 4 + k : 3 + k);
    else             last = 2;
    mem_last = (is_ld && !tmo) ? last - 1 : last;
    exp_pc   = !is_ill && !tmo;
    exp_rw   = (is_alu || is_ld) && !tmo;
    exp_mw   = is_st ? mem_last - 2 : 0;
    case (op)
      T_B:     exp_br = 1'b1;
      T_CBZ:   exp_br = ex_nzvc[2];
      T_BLT:   exp_br = model_flags[3] ^ model_flags[1];
      default: exp_br = 1'b0;
    endcase
    exp_flags = (op == T_ADDS || op == T_SUBS) ? ex_nzvc : model_flags;
    if (rst_cyc > 0) begin
      last      = rst_cyc;
      exp_pc    = 1'b0;
      exp_rw    = 1'b0;
      exp_mw    = is_st ? rst_cyc - 3 : 0;
      tmo       = 1'b0;
      is_ill    = 1'b0;
      exp_flags = 4'b0000;
    end

    @(negedge clk);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    bus.mem_done    = 1'b0;
    {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry} = 4'($urandom);
    #1;
    chk({pfx, "ready_accept"}, bus.instr_ready, 1);

    for (int cyc = 1; cyc <= last + 1; cyc++) begin
      @(negedge clk);
      bus.instr       = $urandom;
      bus.instr_valid = (cyc <= last) ? 1'($urandom) : 1'b0;
      bus.mem_done    = is_mem && (k < MEM_TIMEOUT) && (cyc == 3 + k);
      reset           = (cyc == rst_cyc);
      {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry} =
        (cyc == 2) ? ex_nzvc : 4'($urandom);
      #1;
      if (bus.pc_update) begin pc_cnt++; pc_cyc = cyc; br_seen = bus.br_taken; end
      if (bus.RegWrite) rw_cnt++;
      if (bus.MemWrite) mw_cnt++;
      if (bus.illegal)  il_cnt++;
      if (bus.mem_err)  me_cnt++;
      if (cyc < last && bus.instr_ready) busy_ready++;
      if (cyc >= 3 && cyc <= mem_last && bus.MemRead) mr_cnt++;
      if (cyc == 2) ex_snap = {bus.Reg2Loc, bus.ALUSrc, bus.IorR, bus.ALUOp};
      if (cyc == 3) mem_snap = {bus.xfer, bus.Bor8, bus.MemRead, bus.MemWrite};
      if (cyc == last) wb_snap = {bus.MemToReg, bus.Move, bus.ZorK, bus.ALUOp, bus.RegWrite};
      if (cyc == last + 1) begin
        idle_ctl    = ctl_vec();
        ready_after = bus.instr_ready;
        flags_after = bus.flags;
      end
    end
    reset = 1'b0;
    model_flags = exp_flags;

    chk({pfx, "pc_update_count"}, pc_cnt, exp_pc);
    if (exp_pc) begin
      chk({pfx, "pc_update_cycle"}, pc_cyc, last);
      chk({pfx, "br_taken"}, br_seen, exp_br);
    end
    chk({pfx, "regwrite_count"}, rw_cnt, exp_rw);
    chk({pfx, "memwrite_count"}, mw_cnt, exp_mw);
    chk({pfx, "illegal_count"}, il_cnt, is_ill);
    chk({pfx, "mem_err_count"}, me_cnt, tmo);
    chk({pfx, "ready_while_busy"}, busy_ready, 0);
    chk({pfx, "ready_after"}, ready_after, 1);
    chk({pfx, "flags_after"}, flags_after, exp_flags);
    chk({pfx, "idle_controls"}, idle_ctl, 0);
    if (op != T_ILL && (rst_cyc == 0 || rst_cyc > 2))
      chk({pfx, "ex_controls"}, ex_snap, exp_ex(op));
    if (is_mem && (rst_cyc == 0 || rst_cyc > 3))
      chk({pfx, "mem_controls"}, mem_snap, {byte_op ? 4'b0001 : 4'b1000, byte_op, is_ld, is_st});
    if (is_ld && rst_cyc == 0)
      chk({pfx, "memread_cycles"}, mr_cnt, mem_last - 2);
    if (exp_rw)
      chk({pfx, "wb_controls"}, wb_snap, exp_wb(op));
  endtask

  initial begin
    op_t op;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.mem_done    = 1'b0;
    {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry} = 4'b0;
    reset       = 1'b1;
    model_flags = 4'b0000;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_controls", ctl_vec(), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_ready", bus.instr_ready, 1);
    chk("post_reset_flags", bus.flags, 0);
    chk("post_reset_controls", ctl_vec(), 0);

    run(T_ADDI,  32'h91001441,        4'($urandom), 0, 0);
    run(T_SUBS,  make_ins(T_SUBS),    4'b1000,      0, 0);
    run(T_BLT,   make_ins(T_BLT),     4'($urandom), 0, 0);
    run(T_SUBS,  make_ins(T_SUBS),    4'b1010,      0, 0);
    run(T_BLT,   make_ins(T_BLT),     4'($urandom), 0, 0);
    run(T_LDURB, make_ins(T_LDURB),   4'($urandom), 3, 0);
    run(T_STUR,  make_ins(T_STUR),    4'($urandom), 40, 0);
    run(T_ILL,   32'hFFFFFFFF,        4'($urandom), 0, 0);
    run(T_CBZ,   make_ins(T_CBZ),     4'b0100,      0, 0);
    run(T_CBZ,   make_ins(T_CBZ),     4'b1011,      0, 0);
    run(T_STURB, make_ins(T_STURB),   4'($urandom), MEM_TIMEOUT - 1, 0);
    run(T_LDUR,  make_ins(T_LDUR),    4'($urandom), MEM_TIMEOUT - 1, 0);
    run(T_LDUR,  make_ins(T_LDUR),    4'($urandom), MEM_TIMEOUT, 0);
    run(T_STURB, make_ins(T_STURB),   4'($urandom), 0, 0);
    run(T_MOVK,  make_ins(T_MOVK),    4'($urandom), 0, 0);
    run(T_MOVZ,  make_ins(T_MOVZ),    4'($urandom), 0, 0);
    run(T_B,     make_ins(T_B),       4'($urandom), 0, 0);
    run(T_ADDS,  make_ins(T_ADDS),    4'b1111,      0, 0);
    run(T_LDUR,  make_ins(T_LDUR),    4'($urandom), 40, 5);

    for (int i = 0; i < 40; i++) begin
      op = op_t'($urandom_range(0, 12));
      run(op, make_ins(op), 4'($urandom), int'($urandom_range(0, MEM_TIMEOUT + 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control sequencer for the 64-bit LEGv8 computation datapath (regfile, ALU, datamem, MOVZ/MOVK path).
- Accepts one 32-bit instruction per transaction over a valid/ready handshake.
- Decodes the instruction and steps it through DEC/EX/MEM/WB states, driving every datapath control line.
- Keeps the architectural NZVC flags and reports branch and PC-update decisions to the fetch unit.

Parameters:
MEM_TIMEOUT, 16, maximum cycles spent in MEM waiting for mem_done before aborting with mem_err.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous active-high reset
instr  in  32  instruction word from fetch
instr_valid  in  1  instr is valid this cycle
instr_ready  out  1  controller can accept an instruction
alu_negative, alu_zero, alu_overflow, alu_carry  in  1 each  ALU flag outputs from the datapath
mem_done  in  1  datamem access complete
Reg2Loc, ALUSrc, IorR, MemRead, MemWrite, MemToReg, RegWrite, Move, ZorK, Bor8  out  1 each  datapath controls
ALUOp  out  3  000 pass B, 010 add, 011 sub
xfer  out  4  transfer size: 1000 = 8 bytes, 0001 = 1 byte
flags  out  4  {N,Z,V,C} architectural flags
pc_update  out  1  one-cycle pulse: instruction retired, PC must advance
br_taken  out  1  valid with pc_update: 1 = branch target, 0 = PC+4
illegal  out  1  one-cycle pulse on an undecodable opcode
mem_err  out  1  one-cycle pulse on MEM timeout

Behaviour:
Reset:
- State goes to IDLE; the instruction register and flags clear to 0.
- All outputs are 0 except instr_ready, which is 1 in IDLE.
- A reset asserted in any state wins and aborts the instruction; no write or pulse occurs that cycle.

Decoded opcodes (MSB field):
- ADDI 1001000100, ADDS 10101011000, SUBS 11101011000
- LDUR 11111000010, STUR 11111000000, LDURB 00111000010, STURB 00111000000
- MOVZ 110100101, MOVK 111100101
- B 000101, CBZ 10110100, B.LT 01010100 with cond field 1011
- Any other encoding is illegal.

State sequence:
- IDLE: instr_ready = 1. When instr_valid = 1, latch instr and go to DEC. instr_ready is 0 in every other state.
- DEC: decode only. On an illegal opcode, pulse illegal and return to IDLE with no pc_update. Otherwise go to EX.
- EX: drive the ALU controls:
  - ADDI: ALUSrc=1, IorR=0, ALUOp=010.
  - ADDS/SUBS: Reg2Loc=1, ALUSrc=0, ALUOp 010/011. Latch the alu_* inputs into flags at the end of EX.
  - LDUR/STUR/LDURB/STURB: ALUSrc=1, IorR=1, ALUOp=010. Stores also set Reg2Loc=0.
  - CBZ: Reg2Loc=0, ALUOp=000. br_taken = alu_zero. Pulse pc_update and go to IDLE.
  - B: br_taken=1. Pulse pc_update and go to IDLE.
  - B.LT: br_taken = flags.N xor flags.V, using the stored flags. Pulse pc_update and go to IDLE.
  - Loads and stores go to MEM. All other instructions go to WB.
- MEM:
  - Hold the EX address controls.
  - Assert MemRead (loads) or MemWrite (stores) every cycle. xfer = 0001 for byte ops, 1000 otherwise. Bor8=1 for byte ops.
  - A cycle counter starts at 0.
  - On mem_done: loads go to WB. Stores pulse pc_update (br_taken=0) and go to IDLE.
  - If the counter reaches MEM_TIMEOUT-1 without mem_done, pulse mem_err and go to IDLE with no write and no pc_update.
  - A mem_done arriving on the same cycle as the timeout is accepted, not an error.
- WB (exactly one cycle):
  - RegWrite=1, with the EX/MEM controls still held.
  - Loads: MemToReg=1.
  - MOVZ: Move=1, ZorK=0. MOVK: Move=1, ZorK=1. MOVK also sets MemToReg=0 and ALUOp=000 so the old Rd value reaches the merge.
  - Pulse pc_update with br_taken=0, then go to IDLE.

Rules:
- Controls not listed for a state are 0.
- RegWrite and MemWrite are never high outside WB and MEM respectively.
- flags change only at the end of EX for ADDS/SUBS.
- instr_valid outside IDLE is ignored.

Latency from the acceptance edge to the pc_update cycle:
- branches: 2 cycles
- ALU and MOV instructions: 3 cycles
- stores: 3 + k cycles
- loads: 4 + k cycles
- k = cycles from MEM entry to mem_done.

Test Plan:
1. ADDI X1,X2,#5 (instr=0x91001441) accepted in IDLE -> EX shows ALUSrc=1, IorR=0, ALUOp=010; next cycle RegWrite=1 with pc_update=1, br_taken=0; instr_ready high the following cycle.
2. SUBS with alu_negative=1, alu_overflow=0 in EX, then B.LT -> flags=1000 after EX; the B.LT's pc_update pulse has br_taken=1. Repeat with N=1, V=1 -> br_taken=0.
3. LDURB with mem_done delayed 3 cycles -> MemRead=1, xfer=0001, Bor8=1 for 4 MEM cycles; then WB with MemToReg=1, RegWrite=1; pc_update 7 cycles after acceptance.
4. STUR with mem_done never asserted, MEM_TIMEOUT=16 -> MemWrite high 16 cycles, mem_err pulses once, no pc_update, state returns to IDLE.
5. Opcode 0xFFFFFFFF -> illegal pulses in DEC; no RegWrite, MemWrite or pc_update; instr_ready=1 next cycle.
6. reset asserted during MEM of an LDUR -> next cycle all controls 0, flags=0000, instr_ready=1, no RegWrite ever issued for that load.
